bcd_button_counter: RTL and testbench
=====================================

# bcd_button_counter

Parametrised successor to the two-key board counter. Conditions up to two active-low push-buttons (synchronise, debounce, auto-repeat), maintains a DIGITS-wide BCD up/down count with a selectable wrap or saturate mode, and drives one active-low seven-segment display per digit. It sits directly behind the board KEY pins and in front of the HEX outputs.

## Interface
- DIGITS, 6: BCD digits / displays driven, legal range 1..6.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz), minimum 1.
- REPEAT_DELAY, 25000000: cycles a key must be held before auto-repeat starts (0.5 s).
- REPEAT_RATE, 5000000: cycles between auto-repeat steps (0.1 s).
- WRAP, 1: 1 = modular count, 0 = saturate at 0 and at the all-9s maximum.
- BLANK_LZ, 0: 1 = blank leading-zero digits; digit 0 is never blanked.
- MAX10_CLK1_50 input 1: sole clock, rising edge.
- RESET input 1: synchronous, active-high reset.
- KEY input 2: active-low buttons; KEY[0] = increment, KEY[1] = decrement.
- HEX output 8*DIGITS: display bytes, digit n at [8n+7:8n]; bits 0..6 = segments a..g, bit 7 = DP; all active-low.
- count_bcd output 4*DIGITS: current count, digit n at [4n+3:4n].
- at_max output 1: high when count equals all 9s.
- at_min output 1: high when count equals 0.

## Operation
- Per key: 2-FF synchroniser, then debounce. The debounce counter clears whenever the synchronised level equals the debounced level. Otherwise it increments, and the debounced level flips when the counter reaches DEBOUNCE_CYCLES.
- Press event: debounced level transitions 1→0.
- Repeat events:
  - While the debounced level stays 0, a hold counter runs.
  - The first repeat event fires REPEAT_DELAY cycles after the press event.
  - Later repeat events fire every REPEAT_RATE cycles.
  - Release (debounced 0→1) clears the hold counter.
- Step requests:
  - inc_req = press or repeat event of KEY[0]; dec_req likewise for KEY[1].
  - Both keys debounced-pressed: both hold counters are held at 0, so no repeats occur.
  - inc_req and dec_req in the same cycle: both cancelled, count unchanged.
- BCD arithmetic (at most one step per cycle):
  - Increment: ripple carry; a digit at 9 becomes 0 and carries.
  - Decrement: ripple borrow; a digit at 0 becomes 9 and borrows.
  - Overflow out of the top digit: WRAP=1 gives 0 / all-9s; WRAP=0 holds the count and ignores the request.
- Display:
  - Each digit is encoded 0–9 via the package function.
  - Digit codes 10–15 are unreachable; if present, the encoder outputs 0xFF.
  - DP is always 1 (off).
  - BLANK_LZ=1: any digit above the most-significant non-zero digit outputs 0xFF.
- Reset values:
  - Synchroniser flops and debounced levels: 1 (released). Debounce and hold counters: 0.
  - count_bcd: 0; at_min: 1; at_max: 0.
  - HEX: 0xC0 for digit 0; other digits 0xC0, or 0xFF if BLANK_LZ=1.
- Reset mid-operation:
  - Reset returns everything to the values above in the cycle after RESET is sampled high.
  - A key still held when RESET falls is treated as a new press and is counted once debounce completes.

## Timing
- Count latency: with KEY[i] first sampled low at edge 0 and held, count_bcd changes at edge DEBOUNCE_CYCLES+3 (2 sync + debounce + count register).
- HEX, at_max and at_min are registered and change one edge after count_bcd.
- Release latency: the debounced level returns to 1 at edge DEBOUNCE_CYCLES+2 after KEY is first sampled high.
- Glitches: a raw pulse shorter than DEBOUNCE_CYCLES cycles produces no event.
- Repeats: the first repeat lands REPEAT_DELAY cycles after the press step; subsequent repeats are exactly REPEAT_RATE apart.

## Structure
- Package bcd_button_counter_pkg:
  - seg7 encode function (4-bit digit → 8-bit active-low byte);
  - blank code constant 0xFF;
  - counter width helper function ($clog2 of the largest cycle parameter).
- Sub-module key_conditioner:
  - contains synchroniser, debounce and hold/repeat logic;
  - parameters DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE;
  - outputs: level, press, repeat;
  - instantiated once per key.
- BCD step and display encode live in the top module.

## Test plan
All scenarios use DIGITS=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5.
- Reset: RESET high 2 cycles → count_bcd=0x00, HEX=0xC0C0, at_min=1, at_max=0.
- Single press: KEY[0] low for 10 cycles → count_bcd=0x01 exactly 7 edges after first low sample; HEX[7:0]=0xF9 one edge later.
- Bounce: KEY[0] toggled every 2 cycles for 20 cycles, then high → count unchanged at 0x00.
- Auto-repeat: KEY[0] held 40 cycles from 0x00 → steps at edges 7, 27, 32, 37 → count_bcd=0x04.
- Wrap vs saturate:
  - load 0x99 by repeated presses, then press inc;
  - WRAP=1 → 0x00 with at_min=1;
  - WRAP=0 → stays 0x99 with at_max=1;
  - from 0x00 press dec: WRAP=1 → 0x99, WRAP=0 → 0x00.
- Simultaneous keys and reset:
  - both keys fall on the same cycle and are held 40 cycles → count unchanged.
  - RESET pulsed mid-hold of KEY[1] at count 0x10 → 0x00, then one decrement after debounce → 0x99 (WRAP=1).
  - BLANK_LZ=1 at count 0x05 → HEX=0xFF92.

Source files
------------

// File: rtl/bcd_button_counter_pkg.sv
// Shared types and helpers for the BCD button counter: seven-segment encoding
// and counter sizing.
package bcd_button_counter_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low a..g in bits 0..6, DP (bit 7) held off; non-decimal codes blank.
  function automatic logic [7:0] seg7_encode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'hC0;
      4'd1:    seg = 8'hF9;
      4'd2:    seg = 8'hA4;
      4'd3:    seg = 8'hB0;
      4'd4:    seg = 8'h99;
      4'd5:    seg = 8'h92;
      4'd6:    seg = 8'h82;
      4'd7:    seg = 8'hF8;
      4'd8:    seg = 8'h80;
      4'd9:    seg = 8'h90;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Width able to hold the largest of the three cycle counts (inclusive).
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bcd_button_counter_if.sv
// Board-side pins of the BCD button counter: raw keys in, displays and count out.
interface bcd_button_counter_if #(
  parameter int unsigned DIGITS = 6
);
  logic [1:0]          KEY;
  logic [8*DIGITS-1:0] HEX;
  logic [4*DIGITS-1:0] count_bcd;
  logic                at_max;
  logic                at_min;

  modport master (output KEY, input HEX, count_bcd, at_max, at_min);
  modport slave  (input KEY, output HEX, count_bcd, at_max, at_min);
endinterface

// File: rtl/bcd_button_counter_key_conditioner.sv
// One active-low key: 2-FF synchroniser, debounce, and press/auto-repeat pulses.
module key_conditioner
  import bcd_button_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic hold_clr,
  output logic level,
  output logic press,
  output logic repeat_ev
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] db_cnt;
  logic [CW-1:0] hold_cnt;
  logic          repeating;
  logic [CW-1:0] hold_thr_c;

  // First repeat waits the long delay, later ones the short rate.
  assign hold_thr_c = repeating ? CW'(REPEAT_RATE) : CW'(REPEAT_DELAY);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      level     <= 1'b1;
      db_cnt    <= '0;
      hold_cnt  <= '0;
      repeating <= 1'b0;
      press     <= 1'b0;
      repeat_ev <= 1'b0;
    end else begin
      sync1     <= key;
      sync2     <= sync1;
      press     <= 1'b0;
      repeat_ev <= 1'b0;

      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == CW'(DEBOUNCE_CYCLES)) begin
        db_cnt <= '0;
        level  <= sync2;
        press  <= ~sync2;
      end else begin
        db_cnt <= db_cnt + CW'(1);
      end

      // Hold timer only runs while this key alone is debounced-pressed.
      if (level || hold_clr) begin
        hold_cnt  <= '0;
        repeating <= 1'b0;
      end else if ((hold_cnt + CW'(1)) >= hold_thr_c) begin
        hold_cnt  <= '0;
        repeating <= 1'b1;
        repeat_ev <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bcd_button_counter.sv
// Two-key BCD up/down counter with wrap/saturate and active-low seven-segment
// outputs, one display per digit.
module bcd_button_counter
  import bcd_button_counter_pkg::*;
#(
  parameter int unsigned DIGITS          = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter bit          WRAP            = 1'b1,
  parameter bit          BLANK_LZ        = 1'b0
) (
  input  logic                 MAX10_CLK1_50,
  input  logic                 RESET,
  bcd_button_counter_if.slave  bus
);

  localparam int unsigned NW = 4 * DIGITS;
  localparam int unsigned HW = 8 * DIGITS;

  logic [1:0]    level;
  logic [1:0]    press;
  logic [1:0]    repeat_ev;
  logic          hold_clr_c;
  logic          inc_req_c;
  logic          dec_req_c;
  logic [NW-1:0] count;
  logic [NW-1:0] inc_val_c;
  logic [NW-1:0] dec_val_c;
  logic          inc_ovf_c;
  logic          dec_ovf_c;
  logic [HW-1:0] hex_c;
  logic [HW-1:0] hex_q;
  logic          lead_c;
  logic [3:0]    digit_c;
  logic          is_max_c;
  logic          at_max_q;
  logic          at_min_q;

  // Both keys held together suppresses auto-repeat on both.
  assign hold_clr_c = ~level[0] & ~level[1];

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_conditioner #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_key (
      .clk       (MAX10_CLK1_50),
      .rst       (RESET),
      .key       (bus.KEY[k]),
      .hold_clr  (hold_clr_c),
      .level     (level[k]),
      .press     (press[k]),
      .repeat_ev (repeat_ev[k])
    );
  end

  assign inc_req_c = press[0] | repeat_ev[0];
  assign dec_req_c = press[1] | repeat_ev[1];

  // Ripple carry/borrow; the final carry flags overflow out of the top digit.
  always_comb begin
    inc_val_c = count;
    dec_val_c = count;
    inc_ovf_c = 1'b1;
    dec_ovf_c = 1'b1;
    for (int unsigned n = 0; n < DIGITS; n++) begin
      if (inc_ovf_c) begin
        if (count[4*n +: 4] == 4'd9) begin
          inc_val_c[4*n +: 4] = 4'd0;
        end else begin
          inc_val_c[4*n +: 4] = count[4*n +: 4] + 4'd1;
          inc_ovf_c = 1'b0;
        end
      end
      if (dec_ovf_c) begin
        if (count[4*n +: 4] == 4'd0) begin
          dec_val_c[4*n +: 4] = 4'd9;
        end else begin
          dec_val_c[4*n +: 4] = count[4*n +: 4] - 4'd1;
          dec_ovf_c = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RESET) begin
      count <= '0;
    end else if (inc_req_c && !dec_req_c) begin
      if (WRAP || !inc_ovf_c) count <= inc_val_c;
    end else if (dec_req_c && !inc_req_c) begin
      if (WRAP || !dec_ovf_c) count <= dec_val_c;
    end
  end

  // Scan from the top digit; leading zeros blank until the first non-zero digit.
  always_comb begin
    hex_c    = '0;
    lead_c   = 1'b1;
    digit_c  = '0;
    is_max_c = 1'b1;
    for (int n = int'(DIGITS) - 1; n >= 0; n--) begin
      digit_c = count[4*n +: 4];
      if (digit_c != 4'd9) is_max_c = 1'b0;
      if (BLANK_LZ && lead_c && (digit_c == 4'd0) && (n != 0)) begin
        hex_c[8*n +: 8] = SEG_BLANK;
      end else begin
        hex_c[8*n +: 8] = seg7_encode(digit_c);
        lead_c = 1'b0;
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RESET) begin
      for (int unsigned n = 0; n < DIGITS; n++) begin
        hex_q[8*n +: 8] <= (BLANK_LZ && (n != 0)) ? SEG_BLANK : seg7_encode(4'd0);
      end
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      hex_q    <= hex_c;
      at_max_q <= is_max_c;
      at_min_q <= (count == '0);
    end
  end

  assign bus.count_bcd = count;
  assign bus.HEX       = hex_q;
  assign bus.at_max    = at_max_q;
  assign bus.at_min    = at_min_q;

endmodule

// File: tb/tb_bcd_button_counter.sv
// Scoreboarded bench for bcd_button_counter: wrap, saturate and blanking variants
// share one key/reset stimulus.
module tb_bcd_button_counter;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RR = 5;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  key = 2'b11;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb_q[$];
  logic        mon_en = 1'b0;
  logic [7:0]  prev_w = 8'h00;
  logic [7:0]  model_w = 8'h00;
  logic [7:0]  model_s = 8'h00;
  int unsigned n0 = 0;

  bcd_button_counter_if #(.DIGITS(2)) if_w ();
  bcd_button_counter_if #(.DIGITS(2)) if_s ();
  bcd_button_counter_if #(.DIGITS(2)) if_b ();

  assign if_w.KEY = key;
  assign if_s.KEY = key;
  assign if_b.KEY = key;

  bcd_button_counter #(.DIGITS(2), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .WRAP(1'b1), .BLANK_LZ(1'b0))
    dut_w (.MAX10_CLK1_50(clk), .RESET(rst), .bus(if_w));
  bcd_button_counter #(.DIGITS(2), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .WRAP(1'b0), .BLANK_LZ(1'b0))
    dut_s (.MAX10_CLK1_50(clk), .RESET(rst), .bus(if_s));
  bcd_button_counter #(.DIGITS(2), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .WRAP(1'b1), .BLANK_LZ(1'b1))
    dut_b (.MAX10_CLK1_50(clk), .RESET(rst), .bus(if_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every change of the wrapping counter must match the next expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && (if_w.count_bcd !== prev_w)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected count_bcd=%h at cycle %0d", if_w.count_bcd, cyc);
      end else begin
        e = sb_q.pop_front();
        if (if_w.count_bcd !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL scoreboard: got %h at cycle %0d, expected %h at cycle %0d",
                   if_w.count_bcd, cyc, e.val, e.cyc);
        end
      end
    end
    prev_w = if_w.count_bcd;
  end

  function automatic logic [7:0] bcd_step(input logic [7:0] v, input bit up, input bit wrap);
    int x;
    x = int'(v[7:4]) * 10 + int'(v[3:0]);
    if (up) x = (x == 99) ? (wrap ? 0 : 99) : x + 1;
    else    x = (x == 0)  ? (wrap ? 99 : 0) : x - 1;
    return {4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [15:0] exp_hex(input logic [7:0] v, input bit blank);
    logic [7:0] seg [10];
    seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return {(blank && v[7:4] == 4'd0) ? 8'hFF : seg[int'(v[7:4])], seg[int'(v[3:0])]};
  endfunction

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  // Drive keys low (mask = pressed keys) and queue the steps the hold should produce.
  task automatic start_press(input logic [1:0] mask, input int unsigned hold);
    int unsigned s;
    n0 = cyc;
    if (mask == 2'b01 || mask == 2'b10) begin
      s = DB + 3;
      while (s <= hold + DB + 3) begin
        model_w = bcd_step(model_w, mask == 2'b01, 1'b1);
        model_s = bcd_step(model_s, mask == 2'b01, 1'b0);
        sb_q.push_back('{n0 + 1 + s, model_w});
        s = (s == DB + 3) ? s + RD : s + RR;
      end
    end
    key = ~mask;
  endtask

  task automatic finish_press(input int unsigned hold);
    wait_cyc(n0 + hold);
    key = 2'b11;
    wait_cyc(n0 + hold + 12);
  endtask

  task automatic do_reset();
    if (model_w != 8'h00) sb_q.push_back('{cyc + 1, 8'h00});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_w = 8'h00;
    model_s = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++; if (if_w.count_bcd !== 8'h00) begin errors++; $display("FAIL reset_count: got %h want 00", if_w.count_bcd); end
    checks++; if (if_w.HEX !== 16'hC0C0) begin errors++; $display("FAIL reset_hex: got %h want C0C0", if_w.HEX); end
    checks++; if (if_w.at_min !== 1'b1 || if_w.at_max !== 1'b0) begin errors++; $display("FAIL reset_flags: min=%b max=%b want 1 0", if_w.at_min, if_w.at_max); end
    checks++; if (if_s.count_bcd !== 8'h00 || if_s.HEX !== 16'hC0C0) begin errors++; $display("FAIL reset_sat: got %h/%h want 00/C0C0", if_s.count_bcd, if_s.HEX); end
    checks++; if (if_b.HEX !== 16'hFFC0) begin errors++; $display("FAIL reset_blank_hex: got %h want FFC0", if_b.HEX); end
    prev_w = 8'h00;
    mon_en = 1'b1;
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 5; i++) begin
      key = 2'b10;
      repeat (2) @(negedge clk);
      key = 2'b11;
      repeat (2) @(negedge clk);
    end
    repeat (15) @(negedge clk);
    checks++; if (if_w.count_bcd !== 8'h00) begin errors++; $display("FAIL bounce_count: got %h want 00", if_w.count_bcd); end
    checks++; if (if_s.count_bcd !== 8'h00) begin errors++; $display("FAIL bounce_sat: got %h want 00", if_s.count_bcd); end
  endtask

  task automatic test_single_press();
    start_press(2'b01, 10);
    wait_cyc(n0 + 7);
    checks++; if (if_w.count_bcd !== 8'h00) begin errors++; $display("FAIL press_early: got %h want 00", if_w.count_bcd); end
    wait_cyc(n0 + 8);
    checks++; if (if_w.count_bcd !== 8'h01) begin errors++; $display("FAIL press_edge7: got %h want 01", if_w.count_bcd); end
    checks++; if (if_w.HEX !== 16'hC0C0) begin errors++; $display("FAIL press_hex_lag: got %h want C0C0", if_w.HEX); end
    wait_cyc(n0 + 9);
    checks++; if (if_w.HEX[7:0] !== 8'hF9) begin errors++; $display("FAIL press_hex: got %h want F9", if_w.HEX[7:0]); end
    checks++; if (if_w.at_min !== 1'b0) begin errors++; $display("FAIL press_at_min: got %b want 0", if_w.at_min); end
    finish_press(10);
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL press_pending: %0d entries left want 0", sb_q.size()); end
    checks++; if (if_s.count_bcd !== model_s) begin errors++; $display("FAIL press_sat: got %h want %h", if_s.count_bcd, model_s); end
  endtask

  task automatic test_auto_repeat();
    do_reset();
    start_press(2'b01, 40);
    wait_cyc(n0 + 40);
    checks++; if (if_w.count_bcd !== 8'h04) begin errors++; $display("FAIL repeat_at_40: got %h want 04", if_w.count_bcd); end
    finish_press(40);
    checks++; if (if_w.count_bcd !== model_w) begin errors++; $display("FAIL repeat_final: got %h want %h", if_w.count_bcd, model_w); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL repeat_pending: %0d entries left want 0", sb_q.size()); end
    checks++; if (if_b.HEX !== exp_hex(model_w, 1'b1)) begin errors++; $display("FAIL repeat_blank_hex: got %h want %h", if_b.HEX, exp_hex(model_w, 1'b1)); end
  endtask

  task automatic test_wrap_saturate();
    do_reset();
    for (int i = 0; i < 99; i++) begin
      start_press(2'b01, 8);
      finish_press(8);
      checks++; if (if_s.count_bcd !== model_s) begin errors++; $display("FAIL load_sat: got %h want %h", if_s.count_bcd, model_s); end
    end
    checks++; if (if_w.count_bcd !== 8'h99 || if_w.at_max !== 1'b1) begin errors++; $display("FAIL load_wrap: got %h max=%b want 99 1", if_w.count_bcd, if_w.at_max); end
    checks++; if (if_w.HEX !== 16'h9090) begin errors++; $display("FAIL load_hex: got %h want 9090", if_w.HEX); end
    start_press(2'b01, 8);
    finish_press(8);
    checks++; if (if_w.count_bcd !== 8'h00 || if_w.at_min !== 1'b1) begin errors++; $display("FAIL wrap_up: got %h min=%b want 00 1", if_w.count_bcd, if_w.at_min); end
    checks++; if (if_s.count_bcd !== 8'h99 || if_s.at_max !== 1'b1) begin errors++; $display("FAIL sat_up: got %h max=%b want 99 1", if_s.count_bcd, if_s.at_max); end
    do_reset();
    start_press(2'b10, 8);
    finish_press(8);
    checks++; if (if_w.count_bcd !== 8'h99) begin errors++; $display("FAIL wrap_down: got %h want 99", if_w.count_bcd); end
    checks++; if (if_s.count_bcd !== 8'h00 || if_s.at_min !== 1'b1) begin errors++; $display("FAIL sat_down: got %h min=%b want 00 1", if_s.count_bcd, if_s.at_min); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL wrap_pending: %0d entries left want 0", sb_q.size()); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    start_press(2'b11, 40);
    finish_press(40);
    checks++; if (if_w.count_bcd !== 8'h00) begin errors++; $display("FAIL both_keys: got %h want 00", if_w.count_bcd); end
    checks++; if (if_s.count_bcd !== 8'h00) begin errors++; $display("FAIL both_keys_sat: got %h want 00", if_s.count_bcd); end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      start_press(2'b01, 8);
      finish_press(8);
    end
    checks++; if (if_w.count_bcd !== 8'h10) begin errors++; $display("FAIL mid_load: got %h want 10", if_w.count_bcd); end
    checks++; if (if_b.HEX !== 16'hF9C0) begin errors++; $display("FAIL mid_blank_hex: got %h want F9C0", if_b.HEX); end
    n0 = cyc;
    key = 2'b01;
    wait_cyc(n0 + 3);
    checks++; if (if_w.count_bcd !== 8'h10) begin errors++; $display("FAIL mid_before_rst: got %h want 10", if_w.count_bcd); end
    sb_q.push_back('{n0 + 4, 8'h00});
    sb_q.push_back('{n0 + 12, 8'h99});
    rst = 1'b1;
    wait_cyc(n0 + 4);
    rst = 1'b0;
    checks++; if (if_w.count_bcd !== 8'h00) begin errors++; $display("FAIL mid_rst: got %h want 00", if_w.count_bcd); end
    model_w = 8'h99;
    model_s = 8'h00;
    wait_cyc(n0 + 18);
    key = 2'b11;
    wait_cyc(n0 + 32);
    checks++; if (if_w.count_bcd !== 8'h99) begin errors++; $display("FAIL mid_repress: got %h want 99", if_w.count_bcd); end
    checks++; if (if_s.count_bcd !== 8'h00) begin errors++; $display("FAIL mid_sat: got %h want 00", if_s.count_bcd); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL mid_pending: %0d entries left want 0", sb_q.size()); end
  endtask

  task automatic test_blank();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      start_press(2'b01, 8);
      finish_press(8);
    end
    checks++; if (if_b.HEX !== 16'hFF92) begin errors++; $display("FAIL blank_hex: got %h want FF92", if_b.HEX); end
    checks++; if (if_w.HEX !== 16'hC092) begin errors++; $display("FAIL noblank_hex: got %h want C092", if_w.HEX); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL blank_pending: %0d entries left want 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_single_press();
    test_auto_repeat();
    test_wrap_saturate();
    test_simultaneous();
    test_reset_mid_hold();
    test_blank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: cycle %0d reached time limit", cyc);
    $fatal(1, "time limit");
  end

endmodule
